// File: rtl/checkout_req_arbiter.sv
// Purpose: turns IR / voice / pay-key events into one-shot add/clear commands for the checkout accumulator.
// Latency: event sampled at edge N -> slot pending after N -> cmd_valid high after N+1 (from IDLE).
// Backpressure: one buffered request per slot; a trigger on a pending slot is dropped and flagged on drop_pulse.
//
// Ports:
//   clock, clr_n              system clock, async active-low reset
//   ir_flag, ir_code          IR decoder level + code (0x01..0x04 items, 0xFF clear)
//   voice_code                voice decoder level, 3'b000 = idle
//   pay_a_pulse, pay_b_pulse  one-cycle debounced pay key presses
//   cmd_ready                 accumulator accepts the presented command
//   cmd_valid/kind/amount     command to accumulator (kind 00 item, 01 pay, 10 clear)
//   busy                      any request pending or command presented
//   drop_pulse                one-cycle overflow flag per slot {voice, ir, pay_b, pay_a}
// Build option: define ROUND_ROBIN_EN for rotating item/pay arbitration; default is
// fixed priority pay_a > pay_b > ir > voice. Clear always wins in both builds.
module checkout_req_arbiter #(
    parameter logic [3:0] AMT_ITEM1 = 4'd3,
    parameter logic [3:0] AMT_ITEM2 = 4'd5,
    parameter logic [3:0] AMT_ITEM3 = 4'd8,
    parameter logic [3:0] AMT_ITEM4 = 4'd10,
    parameter logic [3:0] AMT_PAY_A = 4'd5,
    parameter logic [3:0] AMT_PAY_B = 4'd1
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       ir_flag,
    input  logic [7:0] ir_code,
    input  logic [2:0] voice_code,
    input  logic       pay_a_pulse,
    input  logic       pay_b_pulse,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_kind,
    output logic [3:0] cmd_amount,
    output logic       busy,
    output logic [3:0] drop_pulse
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [1:0] KIND_ITEM  = 2'b00;
    localparam logic [1:0] KIND_PAY   = 2'b01;
    localparam logic [1:0] KIND_CLEAR = 2'b10;

    state_t     state, state_nxt;
    logic       ir_prev;
    logic [2:0] voice_prev;
    logic [3:0] pend;
    logic [3:0] amt [4];
    logic       clr_pend;
    logic       gnt_clr;
    logic [1:0] gnt_idx;

    // Trigger decode
    logic       ir_rise, voice_chg;
    logic       ir_req, clr_req, voice_req;
    logic [3:0] ir_amt, voice_amt;
    logic [3:0] trig;
    logic [3:0] trig_amt [4];

    always_comb begin
        ir_rise   = ir_flag & ~ir_prev;
        voice_chg = (voice_code != voice_prev) && (voice_code != 3'b000);
        ir_req    = 1'b0;
        clr_req   = 1'b0;
        ir_amt    = 4'd0;
        voice_req = 1'b0;
        voice_amt = 4'd0;
        case (ir_code)
            8'h01:   begin ir_req = ir_rise; ir_amt = AMT_ITEM1; end
            8'h02:   begin ir_req = ir_rise; ir_amt = AMT_ITEM2; end
            8'h03:   begin ir_req = ir_rise; ir_amt = AMT_ITEM3; end
            8'h04:   begin ir_req = ir_rise; ir_amt = AMT_ITEM4; end
            8'hFF:   clr_req = ir_rise;
            default: ;
        endcase
        case (voice_code)
            3'b100:  begin voice_req = voice_chg; voice_amt = AMT_ITEM1; end
            3'b010:  begin voice_req = voice_chg; voice_amt = AMT_ITEM2; end
            3'b110:  begin voice_req = voice_chg; voice_amt = AMT_ITEM3; end
            3'b001:  begin voice_req = voice_chg; voice_amt = AMT_ITEM4; end
            default: ;
        endcase
        trig        = {voice_req, ir_req, pay_b_pulse, pay_a_pulse};
        trig_amt[0] = AMT_PAY_A;
        trig_amt[1] = AMT_PAY_B;
        trig_amt[2] = ir_amt;
        trig_amt[3] = voice_amt;
    end

    // Slot selection
    logic       sel_any;
    logic [1:0] sel_idx;
`ifdef ROUND_ROBIN_EN
    // rr_ptr holds the slot the next search starts from (one past the last grant)
    logic [1:0] rr_ptr;
    always_comb begin
        sel_any = 1'b0;
        sel_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!sel_any && pend[rr_ptr + 2'(k)]) begin
                sel_any = 1'b1;
                sel_idx = rr_ptr + 2'(k);
            end
        end
    end
`else
    always_comb begin
        sel_any = |pend;
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) sel_idx = 2'(i);
        end
    end
`endif

    // FSM next state and handshake decode
    logic       load;
    logic       done_clr;
    logic [3:0] complete;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_clr  = 1'b0;
        complete  = 4'b0000;
        case (state)
            S_IDLE: begin
                if (clr_pend || sel_any) begin
                    state_nxt = S_GRANT;
                    load      = 1'b1;
                end
            end
            S_GRANT: begin
                if (cmd_ready) begin
                    state_nxt = S_IDLE;
                    if (gnt_clr) begin
                        done_clr = 1'b1;
                        // clear acceptance also discards queued item adds
                        complete = 4'b1100;
                    end else begin
                        complete[gnt_idx] = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state      <= S_IDLE;
            ir_prev    <= 1'b0;
            voice_prev <= 3'b000;
            pend       <= 4'b0000;
            for (int i = 0; i < 4; i++) amt[i] <= 4'd0;
            clr_pend   <= 1'b0;
            gnt_clr    <= 1'b0;
            gnt_idx    <= 2'd0;
            cmd_kind   <= KIND_ITEM;
            cmd_amount <= 4'd0;
            drop_pulse <= 4'b0000;
        end else begin
            state      <= state_nxt;
            ir_prev    <= ir_flag;
            voice_prev <= voice_code;
            for (int i = 0; i < 4; i++) begin
                // a slot completing on this edge may take a new request without a drop
                if (trig[i] && (!pend[i] || complete[i])) begin
                    pend[i] <= 1'b1;
                    amt[i]  <= trig_amt[i];
                end else if (complete[i]) begin
                    pend[i] <= 1'b0;
                end
                drop_pulse[i] <= trig[i] & pend[i] & ~complete[i];
            end
            if (clr_req)       clr_pend <= 1'b1;
            else if (done_clr) clr_pend <= 1'b0;
            if (load) begin
                gnt_clr <= clr_pend;
                gnt_idx <= sel_idx;
                if (clr_pend) begin
                    cmd_kind   <= KIND_CLEAR;
                    cmd_amount <= 4'd0;
                end else begin
                    cmd_kind   <= sel_idx[1] ? KIND_ITEM : KIND_PAY;
                    cmd_amount <= amt[sel_idx];
                end
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n)
            rr_ptr <= 2'd0;
        else if (state == S_GRANT && cmd_ready && !gnt_clr)
            rr_ptr <= gnt_idx + 2'd1;
    end
`endif

    assign cmd_valid = (state == S_GRANT);
    assign busy      = (|pend) | clr_pend | cmd_valid;

endmodule

// File: tb/tb_checkout_req_arbiter.sv
// Purpose: directed self-checking bench for checkout_req_arbiter.
// Latency: inputs driven 1 time unit after the rising edge; outputs checked there too.
// Backpressure: cmd_ready is driven per scenario; accepted commands are logged at the falling edge.
module tb_checkout_req_arbiter;

    logic       clock = 1'b0;
    logic       clr_n;
    logic       ir_flag;
    logic [7:0] ir_code;
    logic [2:0] voice_code;
    logic       pay_a_pulse;
    logic       pay_b_pulse;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_amount;
    logic       busy;
    logic [3:0] drop_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] cmd_q [$];
    int         drop_cnt = 0;

    checkout_req_arbiter dut (
        .clock       (clock),
        .clr_n       (clr_n),
        .ir_flag     (ir_flag),
        .ir_code     (ir_code),
        .voice_code  (voice_code),
        .pay_a_pulse (pay_a_pulse),
        .pay_b_pulse (pay_b_pulse),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_kind    (cmd_kind),
        .cmd_amount  (cmd_amount),
        .busy        (busy),
        .drop_pulse  (drop_pulse)
    );

    always #5 clock = ~clock;

    // Log every accepted command {kind, amount} and every drop indication
    always @(negedge clock) begin
        if (clr_n) begin
            if (cmd_valid && cmd_ready) cmd_q.push_back({cmd_kind, cmd_amount});
            if (drop_pulse != 4'b0000)  drop_cnt = drop_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        clr_n = 1'b0; ir_flag = 1'b0; ir_code = 8'h00; voice_code = 3'b000;
        pay_a_pulse = 1'b0; pay_b_pulse = 1'b0; cmd_ready = 1'b0;
        tick(2);
        n_cmp++; if (cmd_valid !== 1'b0)     begin n_err++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
        n_cmp++; if (cmd_kind !== 2'b00)     begin n_err++; $display("FAIL reset_kind got %b want 00", cmd_kind); end
        n_cmp++; if (cmd_amount !== 4'd0)    begin n_err++; $display("FAIL reset_amount got %0d want 0", cmd_amount); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (drop_pulse !== 4'b0000) begin n_err++; $display("FAIL reset_drop got %b want 0000", drop_pulse); end
        clr_n = 1'b1;
        tick(2);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_ir_hold;
        int base;
        base = cmd_q.size();
        cmd_ready = 1'b1; ir_code = 8'h03; ir_flag = 1'b1;
        tick(1);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL ir_lat1 got valid %b want 0", cmd_valid); end
        tick(1);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL ir_lat2 got valid %b want 1", cmd_valid); end
        n_cmp++; if ({cmd_kind, cmd_amount} !== {2'b00, 4'd8})
            begin n_err++; $display("FAIL ir_cmd got kind %b amt %0d want 00/8", cmd_kind, cmd_amount); end
        tick(18);
        ir_flag = 1'b0;
        tick(6);
        n_cmp++; if (cmd_q.size() - base !== 1)
            begin n_err++; $display("FAIL ir_count got %0d want 1", cmd_q.size() - base); end
    endtask

    task automatic test_voice;
        int base;
        logic [5:0] exp [3];
        exp[0] = {2'b00, 4'd3}; exp[1] = {2'b00, 4'd5}; exp[2] = {2'b00, 4'd5};
        base = cmd_q.size();
        cmd_ready = 1'b1;
        voice_code = 3'b100; tick(50);
        voice_code = 3'b010; tick(5);
        voice_code = 3'b000; tick(5);
        voice_code = 3'b010; tick(5);
        voice_code = 3'b000; tick(6);
        n_cmp++; if (cmd_q.size() - base !== 3)
            begin n_err++; $display("FAIL voice_count got %0d want 3", cmd_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (base + i >= cmd_q.size()) begin n_err++; $display("FAIL voice_cmd%0d got none want %h", i, exp[i]); end
            else if (cmd_q[base + i] !== exp[i]) begin n_err++; $display("FAIL voice_cmd%0d got %h want %h", i, cmd_q[base + i], exp[i]); end
        end
    endtask

    task automatic test_pay_drop;
        int base, d0;
        base = cmd_q.size(); d0 = drop_cnt;
        cmd_ready = 1'b0;
        pay_a_pulse = 1'b1; tick(1);
        pay_a_pulse = 1'b0; tick(2);
        n_cmp++; if ({cmd_valid, cmd_kind, cmd_amount} !== {1'b1, 2'b01, 4'd5})
            begin n_err++; $display("FAIL pay_hold got v%b k%b a%0d want 1/01/5", cmd_valid, cmd_kind, cmd_amount); end
        pay_a_pulse = 1'b1; tick(1);
        n_cmp++; if (drop_pulse !== 4'b0001) begin n_err++; $display("FAIL pay_drop got %b want 0001", drop_pulse); end
        pay_a_pulse = 1'b0; tick(1);
        n_cmp++; if (drop_pulse !== 4'b0000) begin n_err++; $display("FAIL pay_drop_end got %b want 0000", drop_pulse); end
        cmd_ready = 1'b1; tick(6);
        n_cmp++; if (cmd_q.size() - base !== 1)
            begin n_err++; $display("FAIL pay_count got %0d want 1", cmd_q.size() - base); end
        n_cmp++;
        if (base >= cmd_q.size()) begin n_err++; $display("FAIL pay_cmd got none want 15"); end
        else if (cmd_q[base] !== {2'b01, 4'd5}) begin n_err++; $display("FAIL pay_cmd got %h want 15", cmd_q[base]); end
        n_cmp++; if (drop_cnt - d0 !== 1) begin n_err++; $display("FAIL pay_drop_count got %0d want 1", drop_cnt - d0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pay_busy got %b want 0", busy); end
    endtask

    task automatic test_clear_priority;
        int base, d0;
        logic [5:0] exp [3];
        exp[0] = {2'b01, 4'd5}; exp[1] = {2'b10, 4'd0}; exp[2] = {2'b01, 4'd1};
        base = cmd_q.size(); d0 = drop_cnt;
        cmd_ready = 1'b0;
        // pay_a occupies the port so the rest queue up behind it
        pay_a_pulse = 1'b1; tick(1);
        pay_a_pulse = 1'b0; tick(2);
        ir_code = 8'h01; ir_flag = 1'b1; tick(1);
        ir_flag = 1'b0; voice_code = 3'b001; pay_b_pulse = 1'b1; tick(1);
        voice_code = 3'b000; pay_b_pulse = 1'b0; ir_code = 8'hFF; ir_flag = 1'b1; tick(1);
        ir_flag = 1'b0; tick(2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_before got %b want 1", busy); end
        cmd_ready = 1'b1; tick(10);
        n_cmp++; if (cmd_q.size() - base !== 3)
            begin n_err++; $display("FAIL clr_count got %0d want 3", cmd_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (base + i >= cmd_q.size()) begin n_err++; $display("FAIL clr_cmd%0d got none want %h", i, exp[i]); end
            else if (cmd_q[base + i] !== exp[i]) begin n_err++; $display("FAIL clr_cmd%0d got %h want %h", i, cmd_q[base + i], exp[i]); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy_after got %b want 0", busy); end
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL clr_drops got %0d want 0", drop_cnt - d0); end
    endtask

    task automatic test_arbitration;
        int base, d0;
        logic [5:0] exp [4];
`ifdef ROUND_ROBIN_EN
        exp[0] = {2'b01, 4'd5}; exp[1] = {2'b01, 4'd1}; exp[2] = {2'b00, 4'd5}; exp[3] = {2'b01, 4'd5};
`else
        exp[0] = {2'b01, 4'd5}; exp[1] = {2'b01, 4'd5}; exp[2] = {2'b01, 4'd1}; exp[3] = {2'b00, 4'd5};
`endif
        base = cmd_q.size(); d0 = drop_cnt;
        cmd_ready = 1'b0;
        pay_a_pulse = 1'b1; pay_b_pulse = 1'b1; ir_code = 8'h02; ir_flag = 1'b1; tick(1);
        pay_a_pulse = 1'b0; pay_b_pulse = 1'b0; ir_flag = 1'b0; tick(2);
        n_cmp++; if ({cmd_valid, cmd_kind, cmd_amount} !== {1'b1, 2'b01, 4'd5})
            begin n_err++; $display("FAIL arb_first got v%b k%b a%0d want 1/01/5", cmd_valid, cmd_kind, cmd_amount); end
        // pay_a re-enters on the very edge its first request is accepted
        cmd_ready = 1'b1; pay_a_pulse = 1'b1; tick(1);
        pay_a_pulse = 1'b0; tick(12);
        n_cmp++; if (cmd_q.size() - base !== 4)
            begin n_err++; $display("FAIL arb_count got %0d want 4", cmd_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (base + i >= cmd_q.size()) begin n_err++; $display("FAIL arb_cmd%0d got none want %h", i, exp[i]); end
            else if (cmd_q[base + i] !== exp[i]) begin n_err++; $display("FAIL arb_cmd%0d got %h want %h", i, cmd_q[base + i], exp[i]); end
        end
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL arb_drops got %0d want 0", drop_cnt - d0); end
    endtask

    task automatic test_reset_mid_grant;
        int base;
        cmd_ready = 1'b0;
        pay_b_pulse = 1'b1; tick(1);
        pay_b_pulse = 1'b0; tick(2);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b want 1", cmd_valid); end
        clr_n = 1'b0;
        #1;
        n_cmp++; if ({cmd_valid, cmd_kind, cmd_amount, busy, drop_pulse} !== 12'd0)
            begin n_err++; $display("FAIL rst_async got v%b k%b a%0d b%b d%b want all 0", cmd_valid, cmd_kind, cmd_amount, busy, drop_pulse); end
        base = cmd_q.size();
        tick(2);
        clr_n = 1'b1; cmd_ready = 1'b1;
        tick(8);
        n_cmp++; if (cmd_q.size() - base !== 0)
            begin n_err++; $display("FAIL rst_no_cmd got %0d want 0", cmd_q.size() - base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ir_hold();
        test_voice();
        test_pay_drop();
        test_clear_priority();
        test_arbitration();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
